// File: rtl/fft_log_mag.sv
// Per-bin log2-magnitude of complex FFT output. Only the lower NBINS of each NFFT frame are kept.
// Fixed 4-cycle latency, one bin per cycle, no backpressure.
module fft_log_mag #(
    parameter int DATA_W    = 16,
    parameter int NFFT      = 1024,
    parameter int NBINS     = 512,
    parameter int FRAC_BITS = 3,
    parameter int FLOOR     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [DATA_W-1:0] s_re,
    input  logic signed [DATA_W-1:0] s_im,
    input  logic                     s_valid,
    input  logic                     s_last,
    output logic [7:0]               log_out,
    output logic                     log_valid,
    output logic                     log_last,
    output logic                     frame_err
);

    localparam int CNT_W = (NFFT > 1) ? $clog2(NFFT) : 1;
    localparam int SQ_W  = 2 * DATA_W;
    localparam int MAG_W = SQ_W + 1;
    localparam int P_W   = $clog2(MAG_W);
    localparam int L_W   = P_W + FRAC_BITS;
    localparam int D_W   = L_W + 2;

    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(NFFT - 1);
    localparam logic [CNT_W-1:0] LAST_BIN = CNT_W'(NBINS - 1);
    localparam logic [CNT_W:0]   KEEP_LIM = (CNT_W + 1)'(NBINS);
    localparam logic signed [D_W-1:0] FLOOR_S = D_W'(FLOOR);
    localparam logic signed [D_W-1:0] SAT_S   = D_W'(255);

    // Frame position and per-beat tags
    logic [CNT_W-1:0] bin_cnt;
    logic             wrap;
    logic             keep;
    logic             last_tag;
    logic             err_tag;

    assign wrap     = (bin_cnt == MAX_CNT);
    assign keep     = s_valid && ({1'b0, bin_cnt} < KEEP_LIM);
    assign last_tag = keep && (bin_cnt == LAST_BIN);
    assign err_tag  = s_valid && (s_last ^ wrap);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_cnt <= '0;
        end else if (s_valid) begin
            bin_cnt <= (s_last || wrap) ? '0 : bin_cnt + 1'b1;
        end
    end

    // S1: squares
    logic signed [SQ_W-1:0] re_sq_c;
    logic signed [SQ_W-1:0] im_sq_c;
    logic [SQ_W-1:0]        re_sq;
    logic [SQ_W-1:0]        im_sq;
    logic                   v1, l1, e1;

    assign re_sq_c = s_re * s_re;
    assign im_sq_c = s_im * s_im;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            re_sq <= '0;
            im_sq <= '0;
            v1    <= 1'b0;
            l1    <= 1'b0;
            e1    <= 1'b0;
        end else begin
            re_sq <= $unsigned(re_sq_c);
            im_sq <= $unsigned(im_sq_c);
            v1    <= keep;
            l1    <= last_tag;
            e1    <= err_tag;
        end
    end

    // S2: magnitude squared
    logic [MAG_W-1:0] mag;
    logic             v2, l2, e2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mag <= '0;
            v2  <= 1'b0;
            l2  <= 1'b0;
            e2  <= 1'b0;
        end else begin
            mag <= {1'b0, re_sq} + {1'b0, im_sq};
            v2  <= v1;
            l2  <= l1;
            e2  <= e1;
        end
    end

    // S3: MSB position plus the bits just below it; zero-padding the
    // bottom of mag makes small magnitudes fall out of the same slice.
    logic [P_W-1:0]             msb_pos;
    logic [MAG_W+FRAC_BITS-1:0] mag_ext;
    logic [FRAC_BITS-1:0]       frac;
    logic [L_W-1:0]             l_raw;
    logic                       v3, l3, e3;

    always_comb begin
        msb_pos = '0;
        for (int i = 0; i < MAG_W; i++) begin
            if (mag[i]) begin
                msb_pos = P_W'(i);
            end
        end
        mag_ext = {mag, {FRAC_BITS{1'b0}}};
        frac    = mag_ext[msb_pos +: FRAC_BITS];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            l_raw <= '0;
            v3    <= 1'b0;
            l3    <= 1'b0;
            e3    <= 1'b0;
        end else begin
            l_raw <= {msb_pos, frac};
            v3    <= v2;
            l3    <= l2;
            e3    <= e2;
        end
    end

    // S4: floor offset and saturation to 8 bits
    logic signed [D_W-1:0] l_diff;

    assign l_diff = $signed({2'b00, l_raw}) - FLOOR_S;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            log_out   <= 8'd0;
            log_valid <= 1'b0;
            log_last  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (l_diff < 0) begin
                log_out <= 8'd0;
            end else if (l_diff > SAT_S) begin
                log_out <= 8'd255;
            end else begin
                log_out <= l_diff[7:0];
            end
            log_valid <= v3;
            log_last  <= l3;
            frame_err <= e3;
        end
    end

endmodule
